// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux4_rr_arbiter
// Purpose  : Four-way round-robin arbiter for one shared mux4 datapath
//            (item_a..item_d). It registers a one-hot grant and the 2-bit mux
//            select of the owner. The owner keeps the resource for a
//            multi-cycle transaction until it strobes done or drops req.
//            Every release is followed by one idle cycle before the next
//            grant.
// Options  : ARB_TIMEOUT_EN - when defined, an owner is forcibly released
//            after HOLD_MAX busy cycles and timeout pulses for one cycle.
//            When undefined, timeout is tied low and holds are unbounded.
// Revision : 1.0 - initial release
// ============================================================================

module mux4_rr_arbiter #(
  parameter int B        = 32,  // shared datapath width (informational)
  parameter int HOLD_MAX = 16,  // max busy cycles per grant (timeout build)
  parameter int CW       = 5    // hold counter width, 2^CW > HOLD_MAX
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] req,
  input  logic [3:0] done,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t     r_state;
  logic [1:0] r_ptr;     // index of the most recent owner; search starts after it
  logic [1:0] w_win;     // round-robin winner among current requests
  logic       w_found;   // at least one request is pending
  logic       w_rel;     // current owner ends its transaction this edge

  // Parameter sanity: neither block produces hardware; a bad configuration
  // simply shows up as an elaborated block in the hierarchy.
  if (B < 1) begin : g_bad_width
    localparam int c_BAD_B = B;
  end
  if ((1 << CW) <= HOLD_MAX) begin : g_bad_cw
    localparam int c_BAD_CW = CW;
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [CW-1:0] c_CNT_LAST = CW'(HOLD_MAX - 1);
  logic [CW-1:0] r_cnt;  // busy cycles already spent by the current owner
`endif

  // Round-robin search: scan ptr+1, ptr+2, ptr+3, ptr (mod 4), first hit wins.
  always_comb begin
    logic [1:0] idx;
    w_win   = 2'd0;
    w_found = 1'b0;
    idx     = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      idx = r_ptr + 2'(i);
      if (!w_found && req[idx]) begin
        w_found = 1'b1;
        w_win   = idx;
      end
    end
  end

  // Only the owner's own done/req matter; other requesters are ignored.
  always_comb begin
    w_rel = done[sel] | ~req[sel];
  end

  // Arbitration FSM with registered grant, select, busy and timeout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      grant   <= 4'b0000;
      sel     <= 2'b00;
      busy    <= 1'b0;
      r_ptr   <= 2'b11;  // first search after reset starts at requester 0
`ifdef ARB_TIMEOUT_EN
      r_cnt   <= '0;
      timeout <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout <= 1'b0;  // single-cycle pulse unless re-asserted below
`endif
      case (r_state)
        ST_IDLE: begin
          // sel is left alone when nobody asks, so the mux output stays put
          if (w_found) begin
            grant   <= 4'b0001 << w_win;
            sel     <= w_win;
            busy    <= 1'b1;
            r_state <= ST_BUSY;
`ifdef ARB_TIMEOUT_EN
            r_cnt   <= '0;
`endif
          end
        end
        ST_BUSY: begin
          if (w_rel) begin
            // Owner becomes lowest priority; sel keeps pointing at it.
            grant   <= 4'b0000;
            busy    <= 1'b0;
            r_ptr   <= sel;
            r_state <= ST_IDLE;
          end
`ifdef ARB_TIMEOUT_EN
          else if (r_cnt == c_CNT_LAST) begin
            // Forced release: identical to a normal one plus the pulse.
            grant   <= 4'b0000;
            busy    <= 1'b0;
            r_ptr   <= sel;
            r_state <= ST_IDLE;
            timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        default: begin
          r_state <= ST_IDLE;
          grant   <= 4'b0000;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifndef ARB_TIMEOUT_EN
  // Without the hold limit there is never a forced release.
  assign timeout = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux4_rr_arbiter
// Purpose  : Self-checking bench for mux4_rr_arbiter. Directed scenarios plus
//            random request/done traffic compared against a transaction-level
//            reference model of the round-robin rules.
// Revision : 1.0 - initial release
// ============================================================================

module tb_mux4_rr_arbiter;

  localparam int HOLD_MAX = 16;

  logic       clk;
  logic       reset_n;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state: owner index or -1, last owner, last sel, hold count
  int m_owner;
  int m_ptr;
  int m_sel;
  int m_hold;
  bit m_to;

  mux4_rr_arbiter #(
    .B       (32),
    .HOLD_MAX(HOLD_MAX),
    .CW      (5)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .req    (req),
    .done   (done),
    .grant  (grant),
    .sel    (sel),
    .busy   (busy),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_owner = -1;
    m_ptr   = 3;
    m_sel   = 0;
    m_hold  = 0;
    m_to    = 1'b0;
  endfunction

  // One clock edge of the arbitration rules, in transaction terms.
  function automatic void model_edge(input logic [3:0] r, input logic [3:0] d);
    bit found;
    m_to = 1'b0;
    if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (m_ptr + k) % 4;
        if (!found && r[c]) begin
          found   = 1'b1;
          m_owner = c;
          m_sel   = c;
          m_hold  = 0;
        end
      end
    end else if (d[m_owner] || !r[m_owner]) begin
      m_ptr   = m_owner;
      m_owner = -1;
    end else begin
`ifdef ARB_TIMEOUT_EN
      if (m_hold == HOLD_MAX - 1) begin
        m_ptr   = m_owner;
        m_owner = -1;
        m_to    = 1'b1;
      end else begin
        m_hold++;
      end
`endif
    end
  endfunction

  task automatic check_model(input string where);
    logic [3:0] eg;
    eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    check({where, ".grant"},   grant,   eg);
    check({where, ".sel"},     sel,     m_sel);
    check({where, ".busy"},    busy,    (m_owner >= 0));
    check({where, ".timeout"}, timeout, m_to);
  endtask

  // Apply inputs, take one rising edge, then compare 1 time unit later.
  task automatic step(input logic [3:0] r, input logic [3:0] d, input string where);
    req  = r;
    done = d;
    @(posedge clk);
    model_edge(r, d);
    #1;
    check_model(where);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset(input string where);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_model(where);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    req     = 4'b0000;
    done    = 4'b0000;
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst.grant", grant, 4'b0000);
    check("rst.sel", sel, 2'b00);
    check("rst.busy", busy, 1'b0);
    check("rst.timeout", timeout, 1'b0);
    #3;
    reset_n = 1'b1;

    // single requester 2, then release by done
    step(4'b0100, 4'b0000, "t1.grant");
    check("t1.grant_c", grant, 4'b0100);
    check("t1.sel_c", sel, 2'b10);
    step(4'b0100, 4'b0100, "t1.rel");
    check("t1.rel_grant_c", grant, 4'b0000);
    check("t1.rel_sel_c", sel, 2'b10);

    // non-owner done strobes are ignored
    step(4'b0010, 4'b0000, "t3.grant");
    step(4'b0010, 4'b1101, "t3.ignore");
    check("t3.hold_c", grant, 4'b0010);
    step(4'b0010, 4'b0010, "t3.rel");
    check("t3.rel_c", grant, 4'b0000);

    // sole requester 3 with done and req together: regranted after one gap
    step(4'b1000, 4'b0000, "t4.g1");
    check("t4.g1_c", grant, 4'b1000);
    step(4'b1000, 4'b1000, "t4.gap");
    check("t4.gap_c", grant, 4'b0000);
    step(4'b1000, 4'b0000, "t4.g2");
    check("t4.g2_c", grant, 4'b1000);
    step(4'b0000, 4'b0000, "t4.drop");

    // fair rotation with all four requesting, 3 busy cycles each
    for (int n = 0; n < 5; n++) begin
      logic [3:0] oh;
      oh = 4'b0001 << (n % 4);
      step(4'b1111, 4'b0000, "t2.grant");
      check("t2.order_c", grant, oh);
      step(4'b1111, 4'b0000, "t2.hold");
      step(4'b1111, 4'b0000, "t2.hold");
      step(4'b1111, oh, "t2.rel");
      check("t2.gap_c", grant, 4'b0000);
    end
    step(4'b0000, 4'b0000, "t2.idle");

    // reset mid-transaction, then re-arbitrate from requester 0
    step(4'b0100, 4'b0000, "t5.grant");
    step(4'b0100, 4'b0000, "t5.hold");
    pulse_reset("t5.rst");
    step(4'b0110, 4'b0000, "t5.regrant");
    check("t5.owner1_c", grant, 4'b0010);
    step(4'b0000, 4'b0000, "t5.drop");

`ifdef ARB_TIMEOUT_EN
    // owner 0 never finishes: forced out on its HOLD_MAX-th busy edge
    step(4'b0001, 4'b0000, "t6.grant");
    for (int n = 0; n < HOLD_MAX - 1; n++) step(4'b0001, 4'b0000, "t6.hold");
    check("t6.held_c", grant, 4'b0001);
    step(4'b0001, 4'b0000, "t6.force");
    check("t6.to_c", timeout, 1'b1);
    check("t6.rel_c", grant, 4'b0000);
    step(4'b0001, 4'b0000, "t6.regrant");
    check("t6.pulse_c", timeout, 1'b0);
    for (int n = 0; n < HOLD_MAX - 1; n++) step(4'b0001, 4'b0000, "t6.hold2");
    step(4'b0001, 4'b0001, "t6.done_wins");
    check("t6.no_to_c", timeout, 1'b0);
    step(4'b0000, 4'b0000, "t6.idle");
`else
    // without the hold limit an owner may keep the grant indefinitely
    step(4'b0001, 4'b0000, "t6.grant");
    for (int n = 0; n < 3 * HOLD_MAX; n++) step(4'b0001, 4'b0000, "t6.hold");
    check("t6.still_c", grant, 4'b0001);
    step(4'b0000, 4'b0000, "t6.drop");
`endif

    // random traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [3:0] r;
      logic [3:0] d;
      r = 4'($urandom);
      if ($urandom_range(0, 3) != 0) r = r | 4'b0001 << $urandom_range(0, 3);
      d = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'b0000;
      step(r, d, "rnd");
      if ($urandom_range(0, 80) == 0) pulse_reset("rnd.rst");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
